// File: rtl/io_bus_sequencer_if.sv
// Request/response and io_ports bus signals of the IO bus sequencer.
// master: CPU side plus the io_ports read-data return; slave: the sequencer.
interface io_bus_sequencer_if #(
    parameter int unsigned BITS = 16
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [3:0]      req_addr;
    logic [BITS-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_err;
    logic [BITS-1:0] rsp_rdata;
    logic            io_en;
    logic            io_r_or_w;
    logic [3:0]      io_addr;
    logic [BITS-1:0] io_data_in;
    logic [BITS-1:0] io_data_out;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, io_data_out,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  io_en, io_r_or_w, io_addr, io_data_in
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, io_data_out,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output io_en, io_r_or_w, io_addr, io_data_in
    );
endinterface

// File: rtl/io_bus_sequencer.sv
// Turns CPU IN/OUT requests into timed io_ports bus cycles: a setup phase with
// address/direction/data stable, an enable phase, then a one-cycle response.
// Out-of-range addresses get an error response without touching the port bus.
module io_bus_sequencer #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned NUM_PORTS  = 5,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 2
) (
    input logic                clk,
    input logic                rst,
    io_bus_sequencer_if.slave  bus
);

    localparam int unsigned MaxCyc = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [CntW-1:0] SetupLoad  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] AccessLoad = CntW'(ACCESS_CYC - 1);

    if (ACCESS_CYC == 0) begin : g_bad_access
        $error("io_bus_sequencer: ACCESS_CYC must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StResp, StErr} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;

    // Sequencer FSM; every output is a register so the io bus sees clean levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            cnt            <= '0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.io_en      <= 1'b0;
            bus.io_r_or_w  <= 1'b0;
            bus.io_addr    <= '0;
            bus.io_data_in <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        cnt           <= '0;
                        if (32'(bus.req_addr) >= NUM_PORTS) begin
                            state       <= StErr;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end else begin
                            // The io_* registers double as the request latches.
                            bus.io_addr    <= bus.req_addr;
                            bus.io_r_or_w  <= bus.req_write;
                            bus.io_data_in <= bus.req_write ? bus.req_wdata : '0;
                            if (SETUP_CYC == 0) begin
                                state     <= StAccess;
                                bus.io_en <= 1'b1;
                                cnt       <= AccessLoad;
                            end else begin
                                state <= StSetup;
                                cnt   <= SetupLoad;
                            end
                        end
                    end
                end
                StSetup: begin
                    if (cnt == '0) begin
                        state     <= StAccess;
                        bus.io_en <= 1'b1;
                        cnt       <= AccessLoad;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StAccess: begin
                    if (cnt == '0) begin
                        state         <= StResp;
                        bus.io_en     <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        // Read data sampled only at the last enable edge, as-is.
                        bus.rsp_rdata <= bus.io_r_or_w ? '0 : bus.io_data_out;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StResp: begin
                    state          <= StIdle;
                    cnt            <= '0;
                    bus.rsp_valid  <= 1'b0;
                    bus.rsp_rdata  <= '0;
                    bus.io_addr    <= '0;
                    bus.io_r_or_w  <= 1'b0;
                    bus.io_data_in <= '0;
                    bus.req_ready  <= 1'b1;
                end
                StErr: begin
                    state         <= StIdle;
                    cnt           <= '0;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= StIdle;
                    cnt           <= '0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Self-checking bench for io_bus_sequencer: default-timing instance with a
// response scoreboard, plus a SETUP_CYC=0 / ACCESS_CYC=1 instance.
module tb_io_bus_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_bus_sequencer_if #(.BITS(16)) bus_a ();
    io_bus_sequencer_if #(.BITS(16)) bus_b ();

    io_bus_sequencer #(
        .BITS(16), .NUM_PORTS(5), .SETUP_CYC(1), .ACCESS_CYC(2)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    io_bus_sequencer #(
        .BITS(16), .NUM_PORTS(5), .SETUP_CYC(0), .ACCESS_CYC(1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // io_ports stand-in: read data only while enabled, a filler value otherwise.
    logic [15:0] rd_val_a, rd_val_b;
    assign bus_a.io_data_out = bus_a.io_en ? rd_val_a : 16'h5A5A;
    assign bus_b.io_data_out = bus_b.io_en ? rd_val_b : 16'h5A5A;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic       prev_en;
    logic [3:0] prev_addr;
    logic       prev_rw;

    // Response monitor for instance A: pops the scoreboard on each rsp_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(bus_a.rsp_valid), 32'd0);
                end else begin
                    automatic exp_t e = sb.pop_front();
                    check_eq("rsp_cycle", cyc, e.due);
                    check_eq("rsp_err", 32'(bus_a.rsp_err), 32'(e.err));
                    check_eq("rsp_rdata", 32'(bus_a.rsp_rdata), 32'(e.rdata));
                end
            end else begin
                check_eq("idle_rsp_err", 32'(bus_a.rsp_err), 32'd0);
                check_eq("idle_rsp_rdata", 32'(bus_a.rsp_rdata), 32'd0);
            end
            if (bus_a.io_en && prev_en) begin
                check_eq("io_addr_stable", 32'(bus_a.io_addr), 32'(prev_addr));
                check_eq("io_rw_stable", 32'(bus_a.io_r_or_w), 32'(prev_rw));
            end
        end
        prev_en   <= bus_a.io_en;
        prev_addr <= bus_a.io_addr;
        prev_rw   <= bus_a.io_r_or_w;
    end

    // Present a request on A until accepted; push its expected response.
    task automatic issue(input logic wr, input logic [3:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rd, output int acc);
        exp_t e;
        bit   done = 1'b0;
        bus_a.req_valid = 1'b1;
        bus_a.req_write = wr;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wdata;
        rd_val_a        = rd;
        acc             = -1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus_a.req_ready) begin
                e.err   = (addr >= 4'd5);
                e.rdata = (wr || e.err) ? 16'h0 : rd;
                e.due   = cyc + (e.err ? 1 : 4);
                sb.push_back(e);
                acc  = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus_a.req_valid = 1'b0;
        check_eq("accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus_a.req_ready && !bus_a.rsp_valid) seen = 1'b1;
        end
        check_eq("idle_reached", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    int a1, a2;

    initial begin
        rst = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        rd_val_a = '0;
        rd_val_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
        check_eq("rst_io_en", 32'(bus_a.io_en), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check_eq("rst_io_addr", 32'(bus_a.io_addr), 32'd0);
        check_eq("rst_io_data_in", 32'(bus_a.io_data_in), 32'd0);
        check_eq("rst_b_req_ready", 32'(bus_b.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Write D0.
        issue(1'b1, 4'd1, 16'h0001, 16'h0, a1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("wr_cycle_c%0d", k), cyc - a1, k);
            check_eq($sformatf("wr_io_en_c%0d", k), 32'(bus_a.io_en), 32'(k == 2 || k == 3));
            check_eq($sformatf("wr_r_or_w_c%0d", k), 32'(bus_a.io_r_or_w), 32'd1);
            check_eq($sformatf("wr_io_addr_c%0d", k), 32'(bus_a.io_addr), 32'd1);
            if (k <= 3) check_eq($sformatf("wr_data_in_c%0d", k), 32'(bus_a.io_data_in), 32'h1);
        end
        wait_idle();

        // Read A0.
        issue(1'b0, 4'd0, 16'hFFFF, 16'hBEEF, a1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("rd_io_en_c%0d", k), 32'(bus_a.io_en), 32'(k == 2 || k == 3));
            check_eq($sformatf("rd_r_or_w_c%0d", k), 32'(bus_a.io_r_or_w), 32'd0);
            if (k <= 3) check_eq($sformatf("rd_data_in_c%0d", k), 32'(bus_a.io_data_in), 32'h0);
        end
        wait_idle();

        // Out-of-range address.
        issue(1'b0, 4'd7, 16'h0, 16'h0, a1);
        @(negedge clk);
        check_eq("err_io_en_c1", 32'(bus_a.io_en), 32'd0);
        check_eq("err_ready_c1", 32'(bus_a.req_ready), 32'd0);
        check_eq("err_io_addr_c1", 32'(bus_a.io_addr), 32'd0);
        @(negedge clk);
        check_eq("err_io_en_c2", 32'(bus_a.io_en), 32'd0);
        check_eq("err_ready_c2", 32'(bus_a.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back error requests, two cycles apart.
        issue(1'b1, 4'd9, 16'h0, 16'h0, a1);
        issue(1'b1, 4'd15, 16'h0, 16'h0, a2);
        check_eq("err_b2b_gap", a2 - a1, 32'd2);
        wait_idle();

        // Two reads with req_valid held: second accepted in cycle 5.
        issue(1'b0, 4'd2, 16'h0, 16'h1234, a1);
        issue(1'b0, 4'd3, 16'h0, 16'h1234, a2);
        check_eq("rd_b2b_gap", a2 - a1, 32'd5);
        wait_idle();

        // Reset during ACCESS aborts the transaction.
        issue(1'b0, 4'd4, 16'h0, 16'hCAFE, a1);
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_in_access", 32'(bus_a.io_en), 32'd1);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("abort_io_en", 32'(bus_a.io_en), 32'd0);
        check_eq("abort_ready", 32'(bus_a.req_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("abort_no_rsp", 32'(bus_a.rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Instance B: SETUP_CYC=0, ACCESS_CYC=1, read addr 4.
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b0;
        bus_b.req_addr  = 4'd4;
        rd_val_b        = 16'h0F0F;
        a1 = -1;
        for (int i = 0; i < 20 && a1 < 0; i++) begin
            @(negedge clk);
            if (bus_b.req_ready) a1 = cyc;
            @(posedge clk);
            #1;
        end
        bus_b.req_valid = 1'b0;
        check_eq("b_accepted", 32'(a1 >= 0), 32'd1);
        @(negedge clk);
        check_eq("b_io_en_c1", 32'(bus_b.io_en), 32'd1);
        check_eq("b_io_addr_c1", 32'(bus_b.io_addr), 32'd4);
        check_eq("b_rsp_valid_c1", 32'(bus_b.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("b_io_en_c2", 32'(bus_b.io_en), 32'd0);
        check_eq("b_rsp_valid_c2", 32'(bus_b.rsp_valid), 32'd1);
        check_eq("b_rsp_err_c2", 32'(bus_b.rsp_err), 32'd0);
        check_eq("b_rsp_rdata_c2", 32'(bus_b.rsp_rdata), 32'h0F0F);
        @(negedge clk);
        check_eq("b_rsp_valid_c3", 32'(bus_b.rsp_valid), 32'd0);
        check_eq("b_ready_c3", 32'(bus_b.req_ready), 32'd1);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
